ramzor_monitor: RTL and testbench

RAMZOR_MONITOR -- requirements
Module: ramzor_monitor

---
 rtl/ramzor_monitor.sv | 183 ++++++++++++++++++
 tb/tb_ramzor_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ramzor_monitor.sv
// ramzor_monitor: watches a traffic-light controller's outputs and flags illegal combos,
// out-of-order phases and (with RAMZOR_MON_TIMING_EN) phases that run too short or too long.
`default_nettype none

module ramzor_monitor #(
  parameter int red_timer        = 48,
  parameter int red_yellow_timer = 18,
  parameter int green_timer      = 36,
  parameter int yellow_timer     = 18,
  parameter int tol              = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       redLight,
  input  logic       yellowLight,
  input  logic       greenLight,
  input  logic       clear_err,
  output logic       error,
  output logic [2:0] err_code,
  output logic [2:0] phase,
  output logic [7:0] measured,
  output logic [7:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RED    = 3'd1,
    S_RY     = 3'd2,
    S_GREEN  = 3'd3,
    S_YELLOW = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Light vectors are {red, yellow, green}
  localparam logic [2:0] L_R  = 3'b100;
  localparam logic [2:0] L_RY = 3'b110;
  localparam logic [2:0] L_G  = 3'b001;
  localparam logic [2:0] L_Y  = 3'b010;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_ILLEGAL = 3'd1;
  localparam logic [2:0] C_ORDER   = 3'd2;
  localparam logic [2:0] C_SHORT   = 3'd3;
  localparam logic [2:0] C_LONG    = 3'd4;

`ifdef RAMZOR_MON_TIMING_EN
  localparam bit TIMING_EN = 1'b1;
`else
  localparam bit TIMING_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [2:0]  lights_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  meas_q, meas_d;
  logic [7:0]  cyc_q, cyc_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;

  logic [7:0]  cnt_inc;
  logic        dec_legal;
  state_t      dec_state;
  state_t      legal_next;
  int          exp_len;
  int          final_len;
  logic [2:0]  viol;

  always_comb begin
    dec_legal = 1'b1;
    dec_state = S_IDLE;
    case (lights_q)
      L_R:     dec_state = S_RED;
      L_RY:    dec_state = S_RY;
      L_G:     dec_state = S_GREEN;
      L_Y:     dec_state = S_YELLOW;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    legal_next = S_IDLE;
    exp_len    = 0;
    case (state_q)
      S_RED:    begin legal_next = S_RY;     exp_len = red_timer;        end
      S_RY:     begin legal_next = S_GREEN;  exp_len = red_yellow_timer; end
      S_GREEN:  begin legal_next = S_YELLOW; exp_len = green_timer;      end
      S_YELLOW: begin legal_next = S_RED;    exp_len = yellow_timer;     end
      default:  begin legal_next = S_IDLE;   exp_len = 0;                end
    endcase
  end

  // A tick landing on the phase-change edge belongs to the outgoing phase
  assign cnt_inc   = (tick && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
  assign final_len = int'(cnt_inc);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    meas_d  = meas_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    code_d  = code_q;
    viol    = C_NONE;

    case (state_q)
      S_IDLE, S_FAULT: begin
        if (lights_q == L_R) begin
          state_d = S_RED;
          cnt_d   = 8'd0;
        end
      end
      S_RED, S_RY, S_GREEN, S_YELLOW: begin
        if (!dec_legal) begin
          viol = C_ILLEGAL;
        end else if (dec_state == state_q) begin
          cnt_d = cnt_inc;
          if (TIMING_EN && (final_len > exp_len + tol))
            viol = C_LONG;
        end else if (dec_state == legal_next) begin
          state_d = dec_state;
          cnt_d   = 8'd0;
          meas_d  = cnt_inc;
          if (state_q == S_YELLOW)
            cyc_d = cyc_q + 8'd1;
          if (TIMING_EN && (final_len < exp_len - tol))
            viol = C_SHORT;
          else if (TIMING_EN && (final_len > exp_len + tol))
            viol = C_LONG;
        end else begin
          viol = C_ORDER;
        end
        if (viol != C_NONE) begin
          state_d = S_FAULT;
          cnt_d   = 8'd0;
          meas_d  = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // The first cause sticks; a violation coinciding with a clear wins over it
    if (viol != C_NONE) begin
      err_d  = 1'b1;
      code_d = (err_q && !clear_err) ? code_q : viol;
    end else if (clear_err) begin
      err_d  = 1'b0;
      code_d = C_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lights_q <= 3'b000;
      cnt_q    <= 8'd0;
      meas_q   <= 8'd0;
      cyc_q    <= 8'd0;
      err_q    <= 1'b0;
      code_q   <= C_NONE;
    end else begin
      state_q  <= state_d;
      lights_q <= {redLight, yellowLight, greenLight};
      cnt_q    <= cnt_d;
      meas_q   <= meas_d;
      cyc_q    <= cyc_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign error    = err_q;
  assign err_code = code_q;
  assign phase    = state_q;
  assign measured = meas_q;
  assign cycles   = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_ramzor_monitor.sv
// Directed self-checking bench for ramzor_monitor (default and RAMZOR_MON_TIMING_EN builds).
`default_nettype none

module tb_ramzor_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       redLight = 1'b0;
  logic       yellowLight = 1'b0;
  logic       greenLight = 1'b0;
  logic       clear_err = 1'b0;
  logic       error;
  logic [2:0] err_code;
  logic [2:0] phase;
  logic [7:0] measured;
  logic [7:0] cycles;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_RY  = 3'b110;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_BAD = 3'b101;

  ramzor_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .redLight    (redLight),
    .yellowLight (yellowLight),
    .greenLight  (greenLight),
    .clear_err   (clear_err),
    .error       (error),
    .err_code    (err_code),
    .phase       (phase),
    .measured    (measured),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_lights(input logic [2:0] c);
    {redLight, yellowLight, greenLight} = c;
  endtask

  // Present a combo, let it reach the FSM, then hold it for n ticks
  task automatic phase_step(input logic [2:0] c, input int n);
    @(negedge clk);
    tick = 1'b0;
    set_lights(c);
    repeat (2) @(negedge clk);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick = 1'b0;
    clear_err = 1'b0;
    set_lights(3'b000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic nominal_cycle();
    phase_step(L_R, 48);
    phase_step(L_RY, 18);
    phase_step(L_G, 36);
    phase_step(L_Y, 18);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_error", 32'(error), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_measured", 32'(measured), 0);
    chk("rst_cycles", 32'(cycles), 0);
    reset = 1'b0;

    // IDLE ignores non-red combos
    phase_step(L_G, 3);
    phase_step(L_Y, 2);
    chk("idle_phase", 32'(phase), 0);
    chk("idle_error", 32'(error), 0);

    // Two nominal cycles then red
    nominal_cycle();
    nominal_cycle();
    phase_step(L_R, 0);
    chk("nom_error", 32'(error), 0);
    chk("nom_cycles", 32'(cycles), 2);
    chk("nom_measured", 32'(measured), 18);
    chk("nom_phase", 32'(phase), 1);

    // Red held 45 ticks
    do_reset();
    phase_step(L_R, 45);
    phase_step(L_RY, 0);
    chk("short_measured", 32'(measured), 45);
`ifdef RAMZOR_MON_TIMING_EN
    chk("short_code", 32'(err_code), 3);
    chk("short_phase", 32'(phase), 5);
    chk("short_error", 32'(error), 1);
`else
    chk("short_code", 32'(err_code), 0);
    chk("short_phase", 32'(phase), 2);
`endif

    // Green overrun flagged on the 39th tick
    do_reset();
    phase_step(L_R, 48);
    phase_step(L_RY, 18);
    phase_step(L_G, 38);
    chk("long_pre_error", 32'(error), 0);
    chk("long_pre_phase", 32'(phase), 3);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
`ifdef RAMZOR_MON_TIMING_EN
    chk("long_error", 32'(error), 1);
    chk("long_code", 32'(err_code), 4);
    chk("long_phase", 32'(phase), 5);
    chk("long_measured", 32'(measured), 39);
`else
    chk("long_error", 32'(error), 0);
    chk("long_phase", 32'(phase), 3);
`endif

    // Out-of-order R->G, latency, resume, clear
    do_reset();
    phase_step(L_R, 48);
    @(negedge clk);
    set_lights(L_G);
    @(negedge clk);
    chk("order_lat1_error", 32'(error), 0);
    @(negedge clk);
    chk("order_error", 32'(error), 1);
    chk("order_code", 32'(err_code), 2);
    chk("order_phase", 32'(phase), 5);
    phase_step(L_R, 0);
    chk("resume_phase", 32'(phase), 1);
    chk("resume_error", 32'(error), 1);
    chk("resume_code", 32'(err_code), 2);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_error", 32'(error), 0);
    chk("clear_code", 32'(err_code), 0);
    chk("clear_phase", 32'(phase), 1);

    // Violation in the same cycle as clear wins
    @(negedge clk);
    set_lights(L_Y);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clrwin_error", 32'(error), 1);
    chk("clrwin_code", 32'(err_code), 2);

    // Later violation does not overwrite the first cause
    phase_step(L_R, 5);
    phase_step(L_BAD, 0);
    chk("hold_code", 32'(err_code), 2);
    chk("hold_phase", 32'(phase), 5);

    // Illegal combo in GREEN
    do_reset();
    phase_step(L_R, 48);
    phase_step(L_RY, 18);
    phase_step(L_G, 5);
    phase_step(L_BAD, 0);
    chk("illegal_code", 32'(err_code), 1);
    chk("illegal_phase", 32'(phase), 5);
    chk("illegal_measured", 32'(measured), 5);

    // Asynchronous reset mid-RED
    do_reset();
    nominal_cycle();
    phase_step(L_R, 10);
    chk("pre_arst_cycles", 32'(cycles), 1);
    chk("pre_arst_measured", 32'(measured), 18);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_phase", 32'(phase), 0);
    chk("arst_measured", 32'(measured), 0);
    chk("arst_cycles", 32'(cycles), 0);
    chk("arst_error", 32'(error), 0);
    chk("arst_code", 32'(err_code), 0);
    @(negedge clk);
    reset = 1'b0;

`ifndef RAMZOR_MON_TIMING_EN
    // Timing checks disabled: long red is fine, counter saturates
    do_reset();
    phase_step(L_R, 60);
    phase_step(L_RY, 0);
    chk("notime_error", 32'(error), 0);
    chk("notime_measured", 32'(measured), 60);
    do_reset();
    phase_step(L_R, 300);
    phase_step(L_RY, 0);
    chk("sat_measured", 32'(measured), 255);
    chk("sat_error", 32'(error), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
